// File: rtl/usb_spiflash_responder.sv
// SPI mode-0 serial-flash target emulator backed by a byte-wide synchronous memory port.
// The SPI pins are oversampled in the clk domain and a subset of flash commands is decoded.
module usb_spiflash_responder #(
  parameter int ADDR_BITS           = 17,
  parameter int PAGE_SIZE           = 256,
  parameter int SECTOR_SIZE         = 4096,
  parameter int PROGRAM_BUSY_CYCLES = 64,
  parameter int ERASE_BUSY_CYCLES   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_csel,
  input  logic                 spi_clk,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [7:0]           mem_rd_data,
  output logic                 mem_wr_en,
  output logic [7:0]           mem_wr_data,
  output logic [1:0]           status
);

  localparam int PAGE_BITS   = $clog2(PAGE_SIZE);
  localparam int SECTOR_BITS = $clog2(SECTOR_SIZE);
  localparam int BUSY_MAX    = (PROGRAM_BUSY_CYCLES > ERASE_BUSY_CYCLES) ?
                               PROGRAM_BUSY_CYCLES : ERASE_BUSY_CYCLES;
  localparam int BUSY_W      = $clog2(BUSY_MAX + 1);

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FAST  = 8'h0B;
  localparam logic [7:0] CMD_PROG  = 8'h02;
  localparam logic [7:0] CMD_ERASE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_SR, S_PROGRAM, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {OP_NONE, OP_WREN, OP_PROG, OP_ERASE} op_t;

  state_t state, state_next;
  op_t    op;

  logic [1:0] cs_sync, sck_sync, mosi_sync;
  logic       cs_s, sck_s, mosi_s, cs_q, sck_q;
  logic       sck_rise, sck_fall, cs_rise, byte_done;

  logic [2:0]           bit_cnt;
  logic [5:0]           frame_bits;
  logic [6:0]           rx_sr;
  logic [7:0]           rx_byte;
  logic [6:0]           tx_sr;
  logic [7:0]           load_byte;
  logic [15:0]          addr_sr;
  logic [1:0]           addr_cnt;
  logic [ADDR_BITS-1:0] addr, addr_full;
  logic [7:0]           cmd;
  logic                 prog_written;
  logic                 rd_pending;
  logic [7:0]           rd_buf;

  logic                           wel, wip, sweeping;
  logic [SECTOR_BITS-1:0]         sweep_idx;
  logic [ADDR_BITS-SECTOR_BITS-1:0] sweep_base;
  logic [BUSY_W-1:0]              busy_cnt;

  assign cs_s      = cs_sync[1];
  assign sck_s     = sck_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sck_rise  = sck_s & ~sck_q & ~cs_s;
  assign sck_fall  = ~sck_s & sck_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_q;
  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign addr_full = ADDR_BITS'({addr_sr, rx_byte});
  assign status    = {wel, wip};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_s) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            // While busy only status reads are honoured.
            if (wip && rx_byte != CMD_RDSR) begin
              state_next = S_IGNORE;
            end else begin
              case (rx_byte)
                CMD_RDSR:            state_next = S_SR;
                CMD_READ, CMD_FAST:  state_next = S_ADDR;
                CMD_PROG, CMD_ERASE: state_next = wel ? S_ADDR : S_IGNORE;
                default:             state_next = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (byte_done && addr_cnt == 2'd2) begin
            case (cmd)
              CMD_READ: state_next = S_READ;
              CMD_FAST: state_next = S_DUMMY;
              CMD_PROG: state_next = S_PROGRAM;
              default:  state_next = S_IGNORE;
            endcase
          end
        end
        S_DUMMY: if (byte_done) state_next = S_READ;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    load_byte = 8'h00;
    case (state)
      S_SR:    load_byte = {6'b0, wel, wip};
      S_READ:  load_byte = rd_buf;
      default: load_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync      <= 2'b11;
      sck_sync     <= 2'b00;
      mosi_sync    <= 2'b00;
      cs_q         <= 1'b1;
      sck_q        <= 1'b0;
      bit_cnt      <= 3'd0;
      frame_bits   <= 6'd0;
      rx_sr        <= 7'd0;
      tx_sr        <= 7'd0;
      addr_sr      <= 16'd0;
      addr_cnt     <= 2'd0;
      addr         <= '0;
      cmd          <= 8'h00;
      op           <= OP_NONE;
      prog_written <= 1'b0;
      rd_pending   <= 1'b0;
      rd_buf       <= 8'h00;
      spi_miso     <= 1'b0;
      mem_addr     <= '0;
      mem_rd_en    <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_wr_data  <= 8'h00;
      wel          <= 1'b0;
      wip          <= 1'b0;
      sweeping     <= 1'b0;
      sweep_idx    <= '0;
      sweep_base   <= '0;
      busy_cnt     <= '0;
    end else begin
      cs_sync    <= {cs_sync[0], spi_csel};
      sck_sync   <= {sck_sync[0], spi_clk};
      mosi_sync  <= {mosi_sync[0], spi_mosi};
      cs_q       <= cs_s;
      sck_q      <= sck_s;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      rd_pending <= mem_rd_en;
      if (rd_pending) rd_buf <= mem_rd_data;

      if (cs_s) begin
        bit_cnt    <= 3'd0;
        frame_bits <= 6'd0;
        addr_cnt   <= 2'd0;
        spi_miso   <= 1'b0;
      end

      if (sck_rise && state != S_IDLE) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (frame_bits != 6'h3F) frame_bits <= frame_bits + 6'd1;
        if (byte_done) begin
          case (state)
            S_CMD: begin
              cmd <= rx_byte;
              if (!wip && rx_byte == CMD_WREN) op <= OP_WREN;
            end
            S_ADDR: begin
              addr_sr  <= {addr_sr[7:0], rx_byte};
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd2) begin
                addr <= addr_full;
                if (cmd == CMD_READ) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= addr_full;
                end
                if (cmd == CMD_PROG)  op <= OP_PROG;
                if (cmd == CMD_ERASE) op <= OP_ERASE;
              end
            end
            S_DUMMY: begin
              mem_rd_en <= 1'b1;
              mem_addr  <= addr;
            end
            S_PROGRAM: begin
              mem_wr_en    <= 1'b1;
              mem_wr_data  <= rx_byte;
              mem_addr     <= addr;
              addr[PAGE_BITS-1:0] <= addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
              prog_written <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      // A falling edge at bit_cnt==0 starts a new output byte; reads prefetch the next address.
      if (sck_fall && state != S_IDLE) begin
        if (bit_cnt == 3'd0) begin
          spi_miso <= load_byte[7];
          tx_sr    <= load_byte[6:0];
          if (state == S_READ) begin
            addr      <= addr + ADDR_BITS'(1);
            mem_addr  <= addr + ADDR_BITS'(1);
            mem_rd_en <= 1'b1;
          end
        end else begin
          spi_miso <= tx_sr[6];
          tx_sr    <= {tx_sr[5:0], 1'b0};
        end
      end

      if (busy_cnt != '0) busy_cnt <= busy_cnt - BUSY_W'(1);
      if (wip && !sweeping && busy_cnt == '0) wip <= 1'b0;

      if (sweeping) begin
        mem_wr_en   <= 1'b1;
        mem_rd_en   <= 1'b0;
        mem_addr    <= {sweep_base, sweep_idx};
        mem_wr_data <= 8'hFF;
        sweep_idx   <= sweep_idx + SECTOR_BITS'(1);
        if (sweep_idx == '1) sweeping <= 1'b0;
      end

      if (cs_rise) begin
        case (op)
          OP_WREN: wel <= 1'b1;
          OP_PROG: begin
            if (prog_written) begin
              wel      <= 1'b0;
              wip      <= 1'b1;
              busy_cnt <= BUSY_W'(PROGRAM_BUSY_CYCLES - 1);
            end
          end
          OP_ERASE: begin
            if (frame_bits == 6'd32) begin
              wel        <= 1'b0;
              wip        <= 1'b1;
              sweeping   <= 1'b1;
              sweep_idx  <= '0;
              sweep_base <= addr[ADDR_BITS-1:SECTOR_BITS];
              busy_cnt   <= BUSY_W'(ERASE_BUSY_CYCLES - 1);
            end
          end
          default: ;
        endcase
        op           <= OP_NONE;
        prog_written <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_spiflash_responder.sv
// Directed bench for usb_spiflash_responder: SPI master tasks drive frames against a
// behavioural byte memory; expected values are hand-computed constants.
module tb_usb_spiflash_responder;

  localparam int ADDR_BITS = 17;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 spi_csel, spi_clk, spi_mosi, spi_miso;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_rd_en, mem_wr_en;
  logic [7:0]           mem_rd_data, mem_wr_data;
  logic [1:0]           status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_spiflash_responder #(
    .ADDR_BITS(ADDR_BITS),
    .PAGE_SIZE(256),
    .SECTOR_SIZE(4096),
    .PROGRAM_BUSY_CYCLES(200),
    .ERASE_BUSY_CYCLES(256)
  ) dut (
    .clk(clk),
    .reset(reset),
    .spi_csel(spi_csel),
    .spi_clk(spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .status(status)
  );

  // Behavioural backing store plus write/read activity monitors.
  logic [7:0]           mem [0:(1<<ADDR_BITS)-1];
  logic                 pre_we = 1'b0;
  logic [ADDR_BITS-1:0] pre_addr = '0;
  logic [7:0]           pre_data = 8'h00;
  int                   wr_count = 0, rd_count = 0, sector_writes = 0;
  logic                 order_bad = 1'b0, both_bad = 1'b0;
  logic [ADDR_BITS-1:0] prev_sector_addr = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      rd_count++;
    end
    if (mem_rd_en && mem_wr_en) both_bad = 1'b1;
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count++;
      if (mem_addr[16:12] == 5'd1 && mem_wr_data == 8'hFF) begin
        if (sector_writes == 0 && mem_addr != 17'h01000) order_bad = 1'b1;
        if (sector_writes > 0 && mem_addr != prev_sector_addr + 17'd1) order_bad = 1'b1;
        prev_sector_addr = mem_addr;
        sector_writes++;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [ADDR_BITS-1:0] a, input logic [7:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    #10;
    pre_we = 1'b0;
  endtask

  // Mode-0 transfer of the top nbits of tx; miso sampled just before each rising SCK.
  task automatic apply_stimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #40;
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    spi_csel = 1'b0;
    #80;
  endtask

  task automatic spi_end();
    #40;
    spi_csel = 1'b1;
    #80;
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] junk;
    apply_stimulus(b, 8, junk);
  endtask

  task automatic rdsr(output logic [7:0] s);
    spi_begin();
    send(8'h05);
    apply_stimulus(8'h00, 8, s);
    spi_end();
  endtask

  task automatic wren();
    spi_begin();
    send(8'h06);
    spi_end();
  endtask

  logic [7:0] rx;
  logic [7:0] exp_bytes [4];
  int         w0, r0;

  initial begin
    reset = 1'b1; spi_csel = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    #60;
    check_output("reset_status", status, 0);
    check_output("reset_miso", spi_miso, 0);
    check_output("reset_rd_en", mem_rd_en, 0);
    check_output("reset_wr_en", mem_wr_en, 0);
    check_output("reset_mem_addr", mem_addr, 0);
    reset = 1'b0;
    #40;

    poke(17'h00100, 8'hA1); poke(17'h00101, 8'hB2);
    poke(17'h00102, 8'hC3); poke(17'h00103, 8'hD4);
    poke(17'h01000, 8'h5A); poke(17'h01FFF, 8'h5A);
    poke(17'h00FFF, 8'h66); poke(17'h02000, 8'h77);

    rdsr(rx);
    check_output("rdsr_after_reset", rx, 8'h00);
    wren();
    rdsr(rx);
    check_output("rdsr_after_wren", rx, 8'h02);
    check_output("status_after_wren", status, 2'b10);

    exp_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    spi_begin();
    send(8'h0B); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h00, 8, rx);
      check_output($sformatf("fast_read_%0d", i), rx, exp_bytes[i]);
    end
    spi_end();

    spi_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h00, 8, rx);
      check_output($sformatf("read_%0d", i), rx, exp_bytes[i]);
    end
    spi_end();

    w0 = wr_count;
    spi_begin();
    send(8'h02); send(8'h00); send(8'h01); send(8'hFE);
    send(8'h11); send(8'h22); send(8'h33);
    spi_end();
    check_output("prog_write_count", wr_count - w0, 3);
    check_output("prog_mem_1fe", mem[17'h001FE], 8'h11);
    check_output("prog_mem_1ff", mem[17'h001FF], 8'h22);
    check_output("prog_mem_100_wrap", mem[17'h00100], 8'h33);
    check_output("prog_mem_200_untouched", mem[17'h00200], 8'h00);
    rdsr(rx);
    check_output("rdsr_prog_busy", rx, 8'h01);
    #3000;
    rdsr(rx);
    check_output("rdsr_prog_done", rx, 8'h00);

    w0 = wr_count;
    spi_begin();
    send(8'h02); send(8'h00); send(8'h03); send(8'h00); send(8'h55);
    spi_end();
    #200;
    check_output("prog_no_wren_writes", wr_count - w0, 0);
    check_output("prog_no_wren_status", status, 2'b00);

    wren();
    w0 = wr_count;
    spi_begin();
    send(8'h20); send(8'h00); send(8'h12);
    apply_stimulus(8'h34, 4, rx);
    spi_end();
    #2000;
    check_output("erase_partial_writes", wr_count - w0, 0);
    check_output("erase_partial_status", status, 2'b10);

    spi_begin();
    send(8'h20); send(8'h00); send(8'h12); send(8'h34);
    spi_end();
    check_output("erase_busy_status", status, 2'b01);

    r0 = rd_count;
    spi_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    apply_stimulus(8'h00, 8, rx);
    spi_end();
    check_output("read_during_wip_miso", rx, 8'h00);
    check_output("read_during_wip_rd_en", rd_count - r0, 0);

    for (int i = 0; i < 8000 && status != 2'b00; i++) #10;
    check_output("erase_wip_clear", status, 2'b00);
    rdsr(rx);
    check_output("rdsr_erase_done", rx, 8'h00);
    check_output("erase_sector_writes", sector_writes, 4096);
    check_output("erase_ascending", order_bad, 0);
    check_output("erase_mem_1000", mem[17'h01000], 8'hFF);
    check_output("erase_mem_1fff", mem[17'h01FFF], 8'hFF);
    check_output("erase_mem_0fff", mem[17'h00FFF], 8'h66);
    check_output("erase_mem_2000", mem[17'h02000], 8'h77);

    wren();
    spi_begin();
    send(8'h20); send(8'h00); send(8'h20); send(8'h00);
    spi_end();
    #1000;
    check_output("sweep_running", mem_wr_en, 1);
    reset = 1'b1;
    #10;
    check_output("reset_mid_erase_wr_en", mem_wr_en, 0);
    check_output("reset_mid_erase_status", status, 2'b00);
    #40;
    reset = 1'b0;
    w0 = wr_count;
    #500;
    check_output("no_writes_after_reset", wr_count - w0, 0);

    exp_bytes = '{8'h33, 8'hB2, 8'hC3, 8'hD4};
    spi_begin();
    send(8'h03); send(8'h00); send(8'h01); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(8'h00, 8, rx);
      check_output($sformatf("read_after_reset_%0d", i), rx, exp_bytes[i]);
    end
    spi_end();
    check_output("rd_wr_exclusive", both_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
